gf256_inverse_seq: RTL and testbench

Iterative GF(2^8) multiplicative-inverse stage. It sits directly upstream of the S-box affine transform and feeds it. It computes x^254 (= x^-1, with 0 mapped to 0) over the AES field using square-and-multiply, one step per clock. The input and output each use a valid/ready handshake, so the stage can sit between registered pipeline stages.

---
 rtl/gf256_inverse_seq_if.sv | 20 ++
 rtl/gf256_inverse_seq.sv | 121 ++++++++++++
 tb/tb_gf256_inverse_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gf256_inverse_seq_if.sv
// Handshake bundle for the iterative GF(2^8) inverse stage: operand in, result out, busy status.
interface gf256_inverse_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/gf256_inverse_seq.sv
// Iterative GF(2^8) inverse (x^254, 0 -> 0) by square-and-multiply, one step per clock.
// Define GF256_INV_FUSED_AFFINE_EN to fold the AES affine transform into the result capture.
module gf256_inverse_seq #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic                      clk,
  input  logic                      rst,
  gf256_inverse_seq_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] p;
  logic [7:0] acc;
  logic [2:0] cnt;
  logic [7:0] out_data_q;
  logic       out_valid_q;

  logic [7:0] in_sq;
  logic [7:0] p_sq;
  logic [7:0] acc_next;
  logic [7:0] result;

  // Shift-and-add multiply, reducing by POLY whenever bit 7 shifts out.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ POLY) : {aa[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

`ifdef GF256_INV_FUSED_AFFINE_EN
  function automatic logic [7:0] aes_affine(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] c;
    c = 8'h63;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
    end
    return r;
  endfunction
`endif

  assign in_sq    = gf_sq(bus.in_data);
  assign p_sq     = gf_sq(p);
  assign acc_next = gf_mul(acc, p_sq);

`ifdef GF256_INV_FUSED_AFFINE_EN
  assign result = aes_affine(acc_next);
`else
  assign result = acc_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)    state_next = CALC;
      CALC:    if (cnt == 3'd5)     state_next = DONE;
      DONE:    if (bus.out_ready)   state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Sixth CALC step completes acc = x^254; the result is captured from that step's product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p           <= 8'h00;
      acc         <= 8'h00;
      cnt         <= 3'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            p   <= in_sq;
            acc <= in_sq;
            cnt <= 3'd0;
          end
        end
        CALC: begin
          p   <= p_sq;
          acc <= acc_next;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd5) begin
            out_data_q  <= result;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_gf256_inverse_seq.sv
// Self-checking bench for gf256_inverse_seq: field-level reference model plus directed and random traffic.
module tb_gf256_inverse_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   accept_cyc = 0;

  gf256_inverse_seq_if bus ();

  gf256_inverse_seq #(.POLY(8'h1B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: polynomial product followed by long-division reduction by 0x11B.
  function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] binv(input logic [7:0] x);
    logic [7:0] y;
    if (x == 8'h00) return 8'h00;
    for (int k = 1; k < 256; k++) begin
      y = 8'(k);
      if (bmul(x, y) == 8'h01) return y;
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] baffine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] expected(input logic [7:0] x);
`ifdef GF256_INV_FUSED_AFFINE_EN
    return baffine(binv(x));
`else
    return binv(x);
`endif
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: acceptance -> result 6 edges later, held until out_ready.
  int         calc_left = 0;
  bit         holding = 1'b0;
  logic [7:0] exp_result = 8'h00;
  logic [7:0] last_out = 8'h00;

  always @(negedge clk) begin
    bit idle;
    if (rst) begin
      calc_left = 0;
      holding   = 1'b0;
      last_out  = 8'h00;
      checkOutput("rst_out_valid", int'(bus.out_valid), 0);
      checkOutput("rst_out_data", int'(bus.out_data), 0);
      checkOutput("rst_busy", int'(bus.busy), 0);
    end else begin
      idle = (calc_left == 0) && !holding;
      checkOutput("in_ready", int'(bus.in_ready), int'(idle));
      checkOutput("busy", int'(bus.busy), int'(!idle));
      checkOutput("out_valid", int'(bus.out_valid), int'(holding));
      checkOutput("out_data", int'(bus.out_data), int'(holding ? exp_result : last_out));
      if (idle && bus.in_valid) begin
        exp_result = expected(bus.in_data);
        calc_left  = 6;
      end else if (calc_left > 0) begin
        calc_left--;
        if (calc_left == 0) holding = 1'b1;
      end else if (holding && bus.out_ready) begin
        holding  = 1'b0;
        last_out = exp_result;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] x);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    while (!bus.in_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", 0, 1);
    @(posedge clk); #1;
    accept_cyc   = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(output logic [7:0] res);
    int guard;
    guard = 0;
    while (!bus.out_valid && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.out_valid) checkOutput("result_timeout", 0, 1);
    checkOutput("latency", cyc - accept_cyc, 6);
    res = bus.out_data;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] held;
    int         acc_prev;
    logic [7:0] seq [3];

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;

    // Pin the reference model against hand-computed values.
    checkOutput("pin_inv_53", int'(binv(8'h53)), 'hCA);
    checkOutput("pin_inv_02", int'(binv(8'h02)), 'h8D);
    checkOutput("pin_inv_01", int'(binv(8'h01)), 'h01);
    checkOutput("pin_aff_00", int'(baffine(8'h00)), 'h63);
    checkOutput("pin_aff_CA", int'(baffine(8'hCA)), 'hED);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("post_rst_in_ready", int'(bus.in_ready), 1);

    // Known-answer operand.
    applyStimulus(8'h53);
    waitResult(r);
`ifdef GF256_INV_FUSED_AFFINE_EN
    checkOutput("kat_53", int'(r), 'hED);
`else
    checkOutput("kat_53", int'(r), 'hCA);
`endif

    // 00, 01, 02 back to back with out_ready high: one acceptance every 8 cycles.
    seq[0] = 8'h00; seq[1] = 8'h01; seq[2] = 8'h02;
    acc_prev = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(seq[i]);
      if (i > 0) checkOutput("throughput", accept_cyc - acc_prev, 8);
      acc_prev = accept_cyc;
      waitResult(r);
      checkOutput("seq_result", int'(r), int'(expected(seq[i])));
    end

    // Exhaustive sweep.
    for (int x = 0; x < 256; x++) begin
      applyStimulus(8'(x));
      waitResult(r);
`ifdef GF256_INV_FUSED_AFFINE_EN
      checkOutput("sweep_sbox", int'(r), int'(expected(8'(x))));
`else
      if (x != 0) checkOutput("sweep_product", int'(bmul(8'(x), r)), 1);
      else        checkOutput("sweep_zero", int'(r), 0);
`endif
    end

    // Backpressure: result must hold for 20 cycles and a new operand must be ignored.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    applyStimulus(8'h53);
    waitResult(held);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin bus.in_valid = 1'b1; bus.in_data = 8'h11; end
      if (i == 6) bus.in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("bp_out_valid", int'(bus.out_valid), 1);
      checkOutput("bp_out_data", int'(bus.out_data), int'(held));
      checkOutput("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_ready", int'(bus.in_ready), 1);
    checkOutput("bp_release_valid", int'(bus.out_valid), 0);

    // in_valid and out_ready together in DONE: only the output handshake completes.
    bus.out_ready = 1'b0;
    applyStimulus(8'h02);
    waitResult(r);
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h53;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("sim_exit_ready", int'(bus.in_ready), 1);
    checkOutput("sim_exit_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    accept_cyc   = cyc;
    bus.in_valid = 1'b0;
    checkOutput("sim_accept_busy", int'(bus.busy), 1);
    waitResult(r);
    checkOutput("sim_result", int'(r), int'(expected(8'h53)));

    // Asynchronous reset three edges into a calculation.
    @(posedge clk); #1;
    applyStimulus(8'h53);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", int'(bus.out_valid), 0);
    checkOutput("arst_out_data", int'(bus.out_data), 0);
    checkOutput("arst_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("arst_no_valid", int'(bus.out_valid), 0);
    end
    applyStimulus(8'h02);
    waitResult(r);
    checkOutput("arst_next_result", int'(r), int'(expected(8'h02)));

    // Random traffic with random backpressure; the model process checks every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("drain_idle", int'(bus.in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
